aload_sched: RTL

- Sequencing controller for a bank of async-load flip-flop registers. Each entry has an async-load strobe, a load value, a clocked data input and a clock enable.
- Arbitrates async-load requests from NREQ requesters with a round-robin policy.
- For each granted load: drives a one-hot load strobe plus value for a fixed pulse length, then holds off clocked bank writes for a guard interval. This keeps a clock edge from ever coinciding with an async-load event.
- Sits between software-visible config/reset sources and the register bank.

---
 rtl/aload_sched_if.sv | 30 +++
 rtl/aload_sched.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/aload_sched_if.sv
// Purpose: request/grant and bank-drive signals of the async-load sequencer.
// Latency: none; this is a plain signal bundle.
// Backpressure: requesters hold req/addr/val until gnt is seen.
interface aload_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int ADDRW = 3
) ();
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDRW-1:0]  req_addr;
    logic [NREQ*WIDTH-1:0]  req_val;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic [(2**ADDRW)-1:0]  load_en;
    logic [WIDTH-1:0]       load_val;
    logic                   clk_en;
    logic                   busy;

    // Requester side: drives requests, observes grants and bank controls.
    modport master (
        output req, req_addr, req_val,
        input  gnt, done, load_en, load_val, clk_en, busy
    );

    // Sequencer side.
    modport slave (
        input  req, req_addr, req_val,
        output gnt, done, load_en, load_val, clk_en, busy
    );
endinterface

// File: rtl/aload_sched.sv
// Purpose: round-robin sequencer issuing one-hot async-load strobes to a register bank.
// Latency: gnt one cycle after req is seen in IDLE; done PULSE_CYC+GUARD_CYC cycles after gnt.
// Backpressure: one load in flight; other requesters hold req until their gnt.
module aload_sched #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int ADDRW     = 3,
    parameter int PULSE_CYC = 2,
    parameter int GUARD_CYC = 1
) (
    input  logic          clk,
    input  logic          arst,
    aload_sched_if.slave  bus
);
    localparam int NENT   = 2 ** ADDRW;
    localparam int PTRW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CMAX   = (PULSE_CYC > GUARD_CYC) ? PULSE_CYC : GUARD_CYC;
    localparam int CNTW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    // Guard load value is only meaningful when a guard phase exists.
    localparam int G_INIT = (GUARD_CYC > 0) ? GUARD_CYC - 1 : 0;

    typedef enum logic [1:0] {IDLE, PULSE, GUARD} state_t;

    state_t             state_q, state_n;
    logic [CNTW-1:0]    cnt_q, cnt_n;
    logic [PTRW-1:0]    ptr_q, ptr_n;
    logic [PTRW-1:0]    win_q, win_n;
    logic [NREQ-1:0]    gnt_q, gnt_n;
    logic [NREQ-1:0]    done_q, done_n;
    logic [NENT-1:0]    load_en_q, load_en_n;
    logic [WIDTH-1:0]   load_val_q, load_val_n;
    logic               clk_en_q, clk_en_n;
    logic               busy_q, busy_n;

    logic [PTRW-1:0]    win;
    logic               found;
    logic [ADDRW-1:0]   win_addr;
    logic [WIDTH-1:0]   win_val;

    // Round-robin pick: first set req scanning upward from the pointer, wrapping.
    always_comb begin
        int idx;
        idx   = 0;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = PTRW'(idx);
            end
        end
        win_addr = bus.req_addr[int'(win)*ADDRW +: ADDRW];
        win_val  = bus.req_val[int'(win)*WIDTH +: WIDTH];
    end

    // Next-state and next-output logic; every output is a registered copy of these.
    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        ptr_n      = ptr_q;
        win_n      = win_q;
        gnt_n      = '0;
        done_n     = '0;
        load_en_n  = load_en_q;
        load_val_n = load_val_q;
        clk_en_n   = clk_en_q;
        busy_n     = busy_q;
        case (state_q)
            IDLE: begin
                load_en_n = '0;
                clk_en_n  = 1'b1;
                busy_n    = 1'b0;
                if (found) begin
                    state_n    = PULSE;
                    cnt_n      = CNTW'(PULSE_CYC - 1);
                    win_n      = win;
                    ptr_n      = PTRW'((int'(win) + 1) % NREQ);
                    gnt_n      = NREQ'(1) << win;
                    load_en_n  = NENT'(1) << win_addr;
                    load_val_n = win_val;
                    clk_en_n   = 1'b0;
                    busy_n     = 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    load_en_n = '0;
                    if (GUARD_CYC == 0) begin
                        // No guard phase: release the bank clock together with the strobe.
                        state_n  = IDLE;
                        clk_en_n = 1'b1;
                        busy_n   = 1'b0;
                        done_n   = NREQ'(1) << win_q;
                    end else begin
                        state_n = GUARD;
                        cnt_n   = CNTW'(G_INIT);
                    end
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            GUARD: begin
                load_en_n = '0;
                if (cnt_q == '0) begin
                    state_n  = IDLE;
                    clk_en_n = 1'b1;
                    busy_n   = 1'b0;
                    done_n   = NREQ'(1) << win_q;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            default: begin
                state_n   = IDLE;
                load_en_n = '0;
                clk_en_n  = 1'b1;
                busy_n    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops load_en and restores clk_en immediately.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            win_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            load_en_q  <= '0;
            load_val_q <= '0;
            clk_en_q   <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            ptr_q      <= ptr_n;
            win_q      <= win_n;
            gnt_q      <= gnt_n;
            done_q     <= done_n;
            load_en_q  <= load_en_n;
            load_val_q <= load_val_n;
            clk_en_q   <= clk_en_n;
            busy_q     <= busy_n;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.load_en  = load_en_q;
    assign bus.load_val = load_val_q;
    assign bus.clk_en   = clk_en_q;
    assign bus.busy     = busy_q;
endmodule
